// File: rtl/v5_filter_ctrl.sv
// ---------------------------------------------------------------------------
// v5_filter_ctrl
// Sequencer/configurator for the v5 trapezoidal filter.
//  - Latches k/l/M and the trigger threshold while idle and drives them to
//    the filter.
//  - On run_en it flushes the filter (filt_run low), waits out the
//    k+l+PIPE_LAT settling latency, then arms a signed threshold trigger.
//  - After a trigger it searches PEAK_WIN samples for the maximum, presents
//    amplitude + timestamp over a valid/ready handshake, then holds off
//    DEAD_TIME cycles before re-arming.
//  - Rising crossings seen while busy with a pulse are counted in missed_cnt.
// Ports:
//  clk, reset            clock, asynchronous active-high reset
//  run_en                1 = acquire, 0 = return to IDLE
//  cfg_valid/cfg_ready   config write handshake (ready only in IDLE)
//  cfg_k/l/m, cfg_thr    window lengths, M coefficient, signed threshold
//  filt_k/l/m, filt_run  registered settings and run control to the filter
//  filter_data           filter output sample (two's complement)
//  evt_valid/evt_ready   event handshake
//  evt_amp, evt_time     peak amplitude and timestamp of the peak sample
//  missed_cnt            saturating count of triggers lost while busy
// ---------------------------------------------------------------------------
module v5_filter_ctrl #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int CFG_W            = 8,
  parameter int PIPE_LAT         = 4,
  parameter int FLUSH_CYC        = 4,
  parameter int PEAK_WIN         = 16,
  parameter int DEAD_TIME        = 8,
  parameter int TS_W             = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run_en,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [CFG_W-1:0]            cfg_k,
  input  logic [CFG_W-1:0]            cfg_l,
  input  logic [CFG_W-1:0]            cfg_m,
  input  logic [SIZE_FILTER_DATA-1:0] cfg_thr,
  output logic [CFG_W-1:0]            filt_k,
  output logic [CFG_W-1:0]            filt_l,
  output logic [CFG_W-1:0]            filt_m,
  output logic                        filt_run,
  input  logic [SIZE_FILTER_DATA-1:0] filter_data,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [SIZE_FILTER_DATA-1:0] evt_amp,
  output logic [TS_W-1:0]             evt_time,
  output logic [15:0]                 missed_cnt
);

  localparam int CNT_W = 16;
  localparam logic [SIZE_FILTER_DATA-1:0] THR_MAX = {1'b0, {(SIZE_FILTER_DATA-1){1'b1}}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ARMED  = 3'd3,
    ST_PEAK   = 3'd4,
    ST_REPORT = 3'd5,
    ST_DEAD   = 3'd6
  } state_t;

  // A window length of zero is meaningless to the filter; treat it as one.
  function automatic logic [CFG_W-1:0] clamp_len(input logic [CFG_W-1:0] v);
    return (v == {CFG_W{1'b0}}) ? CFG_W'(1) : v;
  endfunction

  // Signed strict greater-than on filter-width samples.
  function automatic logic sgt(input logic [SIZE_FILTER_DATA-1:0] a,
                               input logic [SIZE_FILTER_DATA-1:0] b);
    return $signed(a) > $signed(b);
  endfunction

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CFG_W-1:0]            k_q, k_d, l_q, l_d, m_q, m_d;
  logic [SIZE_FILTER_DATA-1:0] thr_q, thr_d;
  logic [SIZE_FILTER_DATA-1:0] prev_q, prev_d;
  logic [SIZE_FILTER_DATA-1:0] max_q, max_d;
  logic [TS_W-1:0]             ts_q, ts_d;
  logic [TS_W-1:0]             time_q, time_d;
  logic [15:0]                 missed_q, missed_d;
  logic                        cfg_ready_q, cfg_ready_d;
  logic                        filt_run_q, filt_run_d;
  logic                        evt_valid_q, evt_valid_d;

  logic                        cfg_fire_s;
  logic                        above_thr_s;
  logic                        crossing_s;
  logic                        busy_s;
  logic [CNT_W-1:0]            settle_len_s;

  // Next-state logic for the sequencer, configuration and event capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    l_d       = l_q;
    m_d       = m_q;
    thr_d     = thr_q;
    max_d     = max_q;
    time_d    = time_q;
    missed_d  = missed_q;
    ts_d      = ts_q + TS_W'(1);
    prev_d    = filter_data;

    cfg_fire_s   = cfg_valid && (state_q == ST_IDLE);
    above_thr_s  = sgt(filter_data, thr_q);
    // A rising crossing needs the previous sample at or below threshold.
    crossing_s   = above_thr_s && !sgt(prev_q, thr_q);
    busy_s       = (state_q == ST_PEAK) || (state_q == ST_REPORT) || (state_q == ST_DEAD);
    settle_len_s = CNT_W'(k_q) + CNT_W'(l_q) + CNT_W'(PIPE_LAT);

    if (cfg_fire_s) begin
      k_d   = clamp_len(cfg_k);
      l_d   = clamp_len(cfg_l);
      m_d   = cfg_m;
      thr_d = cfg_thr;
    end else begin
      k_d   = k_q;
      l_d   = l_q;
    end

    if (crossing_s && busy_s && (missed_q != 16'hFFFF)) begin
      missed_d = missed_q + 16'd1;
    end else begin
      missed_d = missed_q;
    end

    if (!run_en) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_W'(0);
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(0);
        end
        ST_FLUSH: begin
          if (cnt_q == CNT_W'(FLUSH_CYC - 1)) begin
            state_d = ST_SETTLE;
            cnt_d   = CNT_W'(0);
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          // Settling uses the registered (already clamped) window lengths.
          if (cnt_q == settle_len_s - CNT_W'(1)) begin
            state_d = ST_ARMED;
            cnt_d   = CNT_W'(0);
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        ST_ARMED: begin
          if (above_thr_s) begin
            max_d   = filter_data;
            time_d  = ts_q;
            // The trigger sample is the first of the PEAK_WIN window.
            cnt_d   = CNT_W'(1);
            state_d = (PEAK_WIN <= 1) ? ST_REPORT : ST_PEAK;
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_PEAK: begin
          // Strictly greater only: ties keep the earlier sample.
          if (sgt(filter_data, max_q)) begin
            max_d  = filter_data;
            time_d = ts_q;
          end else begin
            max_d  = max_q;
          end
          if (cnt_q == CNT_W'(PEAK_WIN - 1)) begin
            state_d = ST_REPORT;
            cnt_d   = CNT_W'(0);
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        ST_REPORT: begin
          if (evt_ready) begin
            state_d = (DEAD_TIME == 0) ? ST_ARMED : ST_DEAD;
            cnt_d   = CNT_W'(0);
          end else begin
            state_d = ST_REPORT;
          end
        end
        ST_DEAD: begin
          if (cnt_q == CNT_W'(DEAD_TIME - 1)) begin
            state_d = ST_ARMED;
            cnt_d   = CNT_W'(0);
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_W'(0);
        end
      endcase
    end

    // Outputs are registered from the next state so they align with it.
    cfg_ready_d = (state_d == ST_IDLE);
    filt_run_d  = (state_d != ST_IDLE) && (state_d != ST_FLUSH);
    evt_valid_d = (state_d == ST_REPORT);
  end

  // State, configuration and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_W'(0);
      k_q         <= CFG_W'(1);
      l_q         <= CFG_W'(1);
      m_q         <= CFG_W'(0);
      thr_q       <= THR_MAX;
      prev_q      <= {SIZE_FILTER_DATA{1'b0}};
      max_q       <= {SIZE_FILTER_DATA{1'b0}};
      time_q      <= {TS_W{1'b0}};
      ts_q        <= {TS_W{1'b0}};
      missed_q    <= 16'd0;
      cfg_ready_q <= 1'b1;
      filt_run_q  <= 1'b0;
      evt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      l_q         <= l_d;
      m_q         <= m_d;
      thr_q       <= thr_d;
      prev_q      <= prev_d;
      max_q       <= max_d;
      time_q      <= time_d;
      ts_q        <= ts_d;
      missed_q    <= missed_d;
      cfg_ready_q <= cfg_ready_d;
      filt_run_q  <= filt_run_d;
      evt_valid_q <= evt_valid_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign filt_k     = k_q;
  assign filt_l     = l_q;
  assign filt_m     = m_q;
  assign filt_run   = filt_run_q;
  assign evt_valid  = evt_valid_q;
  assign evt_amp    = max_q;
  assign evt_time   = time_q;
  assign missed_cnt = missed_q;

endmodule
